// File: rtl/adc_pkg.sv
// Shared definitions for the ADC sample path: FSM encoding and sign-magnitude constants.
package adc_pkg;

    localparam int unsigned ADC_DATA_W   = 16;
    localparam int unsigned ADC_SIGN_BIT = ADC_DATA_W - 1;

    // Magnitude field mask and the negative-zero pattern at the default sample width.
    localparam logic [ADC_DATA_W-1:0] ADC_MAG_MASK = {1'b0, {(ADC_DATA_W-1){1'b1}}};
    localparam logic [ADC_DATA_W-1:0] ADC_NEG_ZERO = {1'b1, {(ADC_DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_WAIT  = 3'd4
    } adc_state_e;

    // Folds negative zero onto positive zero; every other word passes unchanged.
    function automatic logic [ADC_DATA_W-1:0] adc_normalize(input logic [ADC_DATA_W-1:0] i_word);
        return (i_word == ADC_NEG_ZERO) ? {ADC_DATA_W{1'b0}} : i_word;
    endfunction

endpackage

// File: rtl/sclk_tick_gen.sv
// Half-period tick generator for the ADC serial clock.
module sclk_tick_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    output logic o_tick_c
);

    localparam int unsigned CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_tick_c = (r_cnt == CNT_LAST);

    // Free-running divider, held at zero while the controller is idle or waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || o_tick_c) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/adc_sample_reader.sv
// Periodic SPI-style ADC frame reader with normalized valid/ready sample output.
module adc_sample_reader
    import adc_pkg::*;
#(
    parameter int unsigned CLK_DIV       = 4,
    parameter int unsigned SAMPLE_PERIOD = 1000,
    parameter int unsigned DATA_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    output logic              adc_cs_n,
    output logic              adc_sclk,
    input  logic              adc_miso,
    output logic [DATA_W-1:0] adc_data,
    output logic              adc_valid,
    input  logic              adc_ready,
    output logic              overrun
);

    localparam int unsigned BIT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam int unsigned PER_W = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [PER_W-1:0]  PER_LAST = PER_W'(SAMPLE_PERIOD - 1);
    localparam logic [DATA_W-1:0] NEG_ZERO = {1'b1, {(DATA_W-1){1'b0}}};

    adc_state_e        r_state;
    logic              r_cs_n;
    logic              r_sclk;
    logic              r_deliver;
    logic [DATA_W-1:0] r_shift;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic [PER_W-1:0]  r_timer;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_overrun;

    logic w_tick;
    logic w_tick_clr;
    logic w_timer_done;
    logic w_start;
    logic w_xfer;

    assign w_tick_clr   = (r_state == ST_IDLE) || (r_state == ST_WAIT);
    assign w_timer_done = (r_timer == PER_LAST);
    assign w_start      = enable && ((r_state == ST_IDLE) ||
                                     ((r_state == ST_WAIT) && w_timer_done));
    assign w_xfer       = r_valid && adc_ready;

    sclk_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_tick_clr),
        .o_tick_c (w_tick)
    );

    // Period timer: restarts on every SETUP entry and saturates at the last count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= '0;
        end else if (w_start) begin
            r_timer <= '0;
        end else if (!w_timer_done) begin
            r_timer <= r_timer + PER_W'(1);
        end
    end

    // Frame sequencer: chip select, serial clock, shift register and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cs_n    <= 1'b1;
            r_sclk    <= 1'b0;
            r_deliver <= 1'b0;
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else begin
            r_deliver <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        r_state   <= ST_SETUP;
                        r_cs_n    <= 1'b0;
                        r_sclk    <= 1'b0;
                        r_bit_cnt <= '0;
                    end
                end
                ST_SETUP: begin
                    if (!enable) begin
                        r_state   <= ST_IDLE;
                        r_cs_n    <= 1'b1;
                        r_sclk    <= 1'b0;
                        r_bit_cnt <= '0;
                    end else if (w_tick) begin
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (!enable) begin
                        r_state   <= ST_IDLE;
                        r_cs_n    <= 1'b1;
                        r_sclk    <= 1'b0;
                        r_bit_cnt <= '0;
                    end else if (w_tick) begin
                        r_sclk <= ~r_sclk;
                        if (!r_sclk) begin
                            // Rising serial edge: sample the data line, MSB first.
                            r_shift <= {r_shift[DATA_W-2:0], adc_miso};
                        end else if (r_bit_cnt == BIT_LAST) begin
                            r_state <= ST_HOLD;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (!enable) begin
                        r_state   <= ST_IDLE;
                        r_cs_n    <= 1'b1;
                        r_sclk    <= 1'b0;
                        r_bit_cnt <= '0;
                    end else if (w_tick) begin
                        r_state   <= ST_WAIT;
                        r_cs_n    <= 1'b1;
                        r_deliver <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (!enable) begin
                        r_state <= ST_IDLE;
                    end else if (w_timer_done) begin
                        r_state   <= ST_SETUP;
                        r_cs_n    <= 1'b0;
                        r_bit_cnt <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cs_n  <= 1'b1;
                    r_sclk  <= 1'b0;
                end
            endcase
        end
    end

    // Output word and handshake: delivery wins over transfer, overwrite flags overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (r_deliver) begin
                r_data    <= (r_shift == NEG_ZERO) ? {DATA_W{1'b0}} : r_shift;
                r_valid   <= 1'b1;
                r_overrun <= r_valid && !adc_ready;
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign adc_cs_n  = r_cs_n;
    assign adc_sclk  = r_sclk;
    assign adc_data  = r_data;
    assign adc_valid = r_valid;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_adc_sample_reader.sv
// Directed bench for adc_sample_reader: frame timing, normalization, handshake, abort and reset.
module tb_adc_sample_reader;

    localparam int unsigned CLK_DIV       = 4;
    localparam int unsigned SAMPLE_PERIOD = 1000;
    localparam int unsigned DATA_W        = 16;
    localparam int          EXP_LAT       = 34 * CLK_DIV + 1;
    localparam int          EXP_LOW       = 34 * CLK_DIV;
    localparam int          BOUND         = 1200;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic              adc_cs_n;
    logic              adc_sclk;
    logic              adc_miso;
    logic [DATA_W-1:0] adc_data;
    logic              adc_valid;
    logic              adc_ready;
    logic              overrun;

    always #5 clk = ~clk;

    adc_sample_reader #(
        .CLK_DIV       (CLK_DIV),
        .SAMPLE_PERIOD (SAMPLE_PERIOD),
        .DATA_W        (DATA_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .adc_cs_n  (adc_cs_n),
        .adc_sclk  (adc_sclk),
        .adc_miso  (adc_miso),
        .adc_data  (adc_data),
        .adc_valid (adc_valid),
        .adc_ready (adc_ready),
        .overrun   (overrun)
    );

    // ADC model: presents bit (15 - rises) of the word until the next rising serial edge.
    logic [15:0] model_word = 16'h0000;
    int          rises = 0;

    always @(negedge adc_cs_n or posedge adc_sclk) begin
        if (adc_sclk) rises <= rises + 1;
        else          rises <= 0;
    end

    assign adc_miso = (rises < 16) ? model_word[4'(15 - rises)] : 1'b0;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Returns at the first falling clock edge with chip select low.
    task automatic wait_cs_fall(output int waited);
        waited = 0;
        @(negedge clk);
        while (adc_cs_n && waited < BOUND) begin
            @(negedge clk);
            waited++;
        end
    endtask

    // Measures cycles from frame start to valid and the chip-select low time.
    task automatic run_frame(output int waited, output int lat, output int low);
        wait_cs_fall(waited);
        lat = 0;
        low = 0;
        while (!adc_valid && lat < BOUND) begin
            if (!adc_cs_n) low++;
            @(negedge clk);
            lat++;
        end
    endtask

    typedef struct {
        logic [15:0] word;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int waited, lat, low, n, drops, ov, holdbad, vcnt, lowcnt;

        vecs[0] = '{16'h800F, 16'h800F};
        vecs[1] = '{16'h8000, 16'h0000};
        vecs[2] = '{16'h1234, 16'h1234};
        vecs[3] = '{16'hFFFF, 16'hFFFF};
        vecs[4] = '{16'h0000, 16'h0000};

        rst_n      = 1'b0;
        enable     = 1'b0;
        adc_ready  = 1'b1;
        model_word = vecs[0].word;
        repeat (3) @(negedge clk);
        check("rst_cs_n",    adc_cs_n,  1);
        check("rst_sclk",    adc_sclk,  0);
        check("rst_data",    adc_data,  0);
        check("rst_valid",   adc_valid, 0);
        check("rst_overrun", overrun,   0);

        // Table-driven frames with the consumer always ready.
        enable = 1'b1;
        rst_n  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            model_word = vecs[i].word;
            run_frame(waited, lat, low);
            check("frame_lat",     lat,       EXP_LAT);
            check("frame_cs_low",  low,       EXP_LOW);
            check("frame_data",    adc_data,  vecs[i].exp);
            check("frame_rises",   rises,     16);
            check("frame_overrun", overrun,   0);
            @(negedge clk);
            check("frame_valid_1cyc", adc_valid, 0);
        end

        // Consumer stalled across two frames: overwrite with a single overrun pulse.
        adc_ready  = 1'b0;
        model_word = 16'h0006;
        run_frame(waited, lat, low);
        check("stall_a_lat",     lat,      EXP_LAT);
        check("stall_a_data",    adc_data, 16'h0006);
        check("stall_a_overrun", overrun,  0);
        model_word = 16'h0010;
        n = 0; drops = 0; ov = 0; holdbad = 0;
        while (adc_data !== 16'h0010 && n < BOUND) begin
            @(negedge clk);
            n++;
            if (!adc_valid) drops++;
            if (overrun) ov++;
            if (adc_data !== 16'h0006 && adc_data !== 16'h0010) holdbad++;
        end
        repeat (3) begin
            @(negedge clk);
            if (!adc_valid) drops++;
            if (overrun) ov++;
        end
        check("stall_b_data",   adc_data, 16'h0010);
        check("stall_period",   n,        SAMPLE_PERIOD);
        check("stall_drops",    drops,    0);
        check("stall_hold",     holdbad,  0);
        check("stall_overrun",  ov,       1);

        // Ready rises exactly in the delivery cycle of the next frame.
        model_word = 16'h0123;
        wait_cs_fall(waited);
        ov = 0;
        for (int k = 1; k <= EXP_LAT + 1; k++) begin
            @(negedge clk);
            if (overrun) ov++;
            if (k == EXP_LAT - 1) adc_ready = 1'b1;
            if (k == EXP_LAT) begin
                check("same_cyc_valid", adc_valid, 1);
                check("same_cyc_data",  adc_data,  16'h0123);
            end
            if (k == EXP_LAT + 1) check("same_cyc_clear", adc_valid, 0);
        end
        check("same_cyc_overrun", ov, 0);

        // Enable dropped after the fifth serial rising edge.
        model_word = 16'h0555;
        wait_cs_fall(waited);
        n = 0;
        while (rises < 5 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        check("abort_sclk_before", adc_sclk, 1);
        enable = 1'b0;
        @(negedge clk);
        check("abort_cs_n", adc_cs_n, 1);
        check("abort_sclk", adc_sclk, 0);
        vcnt = 0; lowcnt = 0;
        repeat (SAMPLE_PERIOD + 100) begin
            @(negedge clk);
            if (adc_valid) vcnt++;
            if (!adc_cs_n) lowcnt++;
        end
        check("abort_no_valid", vcnt,   0);
        check("abort_idle_cs",  lowcnt, 0);
        model_word = 16'h0AAA;
        enable     = 1'b1;
        run_frame(waited, lat, low);
        check("reenable_wait", waited,   0);
        check("reenable_lat",  lat,      EXP_LAT);
        check("reenable_data", adc_data, 16'h0AAA);

        // Asynchronous reset in the middle of the shift phase.
        model_word = 16'h7FFE;
        wait_cs_fall(waited);
        n = 0;
        while (rises < 3 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        #1 rst_n = 1'b0;
        #1;
        check("async_cs_n",    adc_cs_n,  1);
        check("async_sclk",    adc_sclk,  0);
        check("async_data",    adc_data,  0);
        check("async_valid",   adc_valid, 0);
        check("async_overrun", overrun,   0);
        model_word = 16'h8001;
        #1 rst_n = 1'b1;
        run_frame(waited, lat, low);
        check("post_rst_wait",  waited,   0);
        check("post_rst_lat",   lat,      EXP_LAT);
        check("post_rst_low",   low,      EXP_LOW);
        check("post_rst_data",  adc_data, 16'h8001);
        check("post_rst_rises", rises,    16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc_sample_reader.md
# adc_sample_reader

Serial front end for the Smart Home temperature path. Periodically runs a 16-bit read frame on an external ADC's SPI-style interface (`adc_cs_n`, `adc_sclk`, `adc_miso`). Each captured sign-magnitude sample is normalized and presented through a valid/ready handshake as the `adc_data` word consumed by the temperature calculator.

## Interface
- `CLK_DIV`, 4: `clk` cycles per `adc_sclk` half period (≥2).
- `SAMPLE_PERIOD`, 1000: `clk` cycles between frame starts.
- `DATA_W`, 16: sample width; bit `DATA_W-1` is the sign, the rest is magnitude.

Ports:
- `clk` in 1: single system clock.
- `rst_n` in 1: reset. Asynchronous, active-low.
- `enable` in 1: run periodic conversions.
- `adc_cs_n` out 1: ADC chip select, active-low.
- `adc_sclk` out 1: serial clock; idles low.
- `adc_miso` in 1: serial data from the ADC, MSB first.
- `adc_data` out `DATA_W`: captured sample, sign-magnitude.
- `adc_valid` out 1: `adc_data` is valid.
- `adc_ready` in 1: consumer accepts the word.
- `overrun` out 1: one-cycle pulse when an unaccepted word is overwritten.

## Operation
- Reset values: `adc_cs_n`=1, `adc_sclk`=0, `adc_data`=0, `adc_valid`=0, `overrun`=0. The period timer and bit counter clear; the FSM goes to IDLE.
- FSM states: IDLE → SETUP → SHIFT → HOLD → WAIT → SETUP …
- IDLE: while `enable`=0, stay here. On `enable`=1, go to SETUP on the next cycle. There is no initial wait.
- SETUP: `adc_cs_n`=0 for `CLK_DIV` cycles, with `adc_sclk` low.
- SHIFT: `adc_sclk` toggles every `CLK_DIV` cycles, giving 16 rising edges.
  - On the `clk` edge that drives `adc_sclk` high, `adc_miso` shifts into the LSB of the shift register, so bits arrive MSB first.
  - After the 16th falling edge, go to HOLD.
- HOLD: `adc_cs_n` stays low for `CLK_DIV` cycles, then goes high and the word is delivered. Go to WAIT.
- WAIT: hold until the period timer expires, then go to SETUP.
  - The timer counts from the cycle SETUP was entered.
  - If `SAMPLE_PERIOD` is shorter than the frame length (34·`CLK_DIV`), the next SETUP starts the cycle after HOLD ends.
- Normalization: negative zero (sign set, magnitude 0) is delivered as 0x0000. All other words pass unchanged.
- Delivery and handshake:
  - Delivery loads `adc_data` and sets `adc_valid`.
  - A transfer occurs on any cycle with `adc_valid` && `adc_ready`. After a transfer, `adc_valid` clears on the next cycle.
  - While `adc_valid`=1, `adc_data` is stable until a transfer or an overwrite.
  - Delivery with `adc_valid`=1 and no transfer that cycle: the new word overwrites `adc_data`, `adc_valid` stays 1, and `overrun` pulses.
  - Delivery in the same cycle as a transfer: load the new word, keep `adc_valid`=1, no `overrun`.
- `enable` deasserted mid-frame (SETUP, SHIFT or HOLD):
  - Abort: next cycle `adc_cs_n`=1 and `adc_sclk`=0.
  - Partial bits are discarded, nothing is delivered, and the FSM returns to IDLE.
  - A word already held with `adc_valid`=1 stays until transferred.
- `enable` deasserted in WAIT: go to IDLE.
- `rst_n` asserted mid-frame: all outputs go to their reset values immediately (asynchronous).

## Timing
- `adc_cs_n` low time: exactly 34·`CLK_DIV` cycles (136 at the default).
- `adc_valid` rises 1 cycle after `adc_cs_n` rises.
- Frame start to `adc_valid`: 34·`CLK_DIV`+1 cycles.
- `adc_sclk` frequency: `clk`/(2·`CLK_DIV`); duty cycle 50%.
- All outputs are registered. No combinational path from `adc_ready` or `adc_miso` to any output.

## Structure
- Shared package `adc_pkg`:
  - FSM state encoding (IDLE, SETUP, SHIFT, HOLD, WAIT).
  - Sign-bit index and magnitude-mask constants.
  - Negative-zero constant (0x8000 at the default width), reused by the temperature calculator.
- Sub-module `sclk_tick_gen`: counts `CLK_DIV` and emits a one-cycle half-period tick. Its count clears whenever the FSM enters SETUP or goes to IDLE.
- Top level holds the FSM, period timer, 16-bit shift register, bit counter (0–15), output register and handshake logic.

## Test plan
- ADC model drives 0x800F, `adc_ready`=1:
  - `adc_data`=0x800F.
  - `adc_valid` is high 137 cycles after `adc_cs_n` falls, for 1 cycle.
  - Exactly 16 `adc_sclk` rising edges.
- ADC model drives 0x8000 → `adc_data`=0x0000, `adc_valid`=1.
- `adc_ready`=0 across two frames (0x0006, then 0x0010):
  - `adc_data` holds 0x0006 until the second delivery, then becomes 0x0010.
  - `overrun` pulses once; `adc_valid` never drops.
- `adc_ready` asserted in the exact delivery cycle of the next frame → `adc_valid` stays 1, `adc_data` updates, no `overrun`.
- `enable` dropped after the 5th `adc_sclk` rise:
  - Next cycle `adc_cs_n`=1 and `adc_sclk`=0.
  - No `adc_valid`; the re-enabled frame captures correctly.
- `rst_n` pulsed low mid-SHIFT:
  - Outputs reach reset values without waiting for a `clk` edge.
  - After release with `enable`=1, the first frame starts on the first clock edge after `rst_n` releases (FSM enters SETUP).
